// File: rtl/isa_types.sv
// Shared RV32 hart types: ISA widths, opcodes, decoded-field types and the architectural state bundle.
// No latency: declarations only.
// No backpressure: declarations only.
package isa_types;

    localparam int XLEN      = 32;
    localparam int ILEN      = 32;
    localparam int NUM_XREGS = 32;
    localparam int MEM_BYTES = 3072;
    localparam int MEM_WORDS = MEM_BYTES / 4;

    typedef enum logic [6:0] {
        OP_LOAD  = 7'b0000011,
        OP_IMM   = 7'b0010011,
        OP_STORE = 7'b0100011
    } opcode_t;

    typedef logic [4:0] rv_reg_t;

    typedef enum logic [1:0] {
        WIDTH_BYTE,
        WIDTH_HALF,
        WIDTH_WORD
    } write_width_t;

    typedef enum logic [1:0] {
        FETCH,
        LOAD,
        WRITEBACK
    } stage_t;

    typedef struct packed {
        logic [XLEN-1:0]                  pc;
        logic [0:NUM_XREGS-1][XLEN-1:0]   xregs;
    } state_t;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_BYTE = 3'b000;
    localparam logic [2:0] F3_HALF = 3'b001;
    localparam logic [2:0] F3_WORD = 3'b010;

    // Load and store share the funct3 encoding for access width.
    function automatic write_width_t width_of(input logic [2:0] funct3);
        case (funct3)
            F3_BYTE: return WIDTH_BYTE;
            F3_HALF: return WIDTH_HALF;
            default: return WIDTH_WORD;
        endcase
    endfunction

    function automatic logic width_valid(input logic [2:0] funct3);
        return (funct3 == F3_BYTE) || (funct3 == F3_HALF) || (funct3 == F3_WORD);
    endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Splits an RV32 instruction word into register indices, function fields and sign-extended immediates.
// Latency: purely combinational.
// No backpressure: stateless.
module instruction_decoder
    import isa_types::*;
(
    input  logic [ILEN-1:0] instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s
);

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};

endmodule

// File: rtl/rv32_stage_hart.sv
// RV32 subset hart (ADDI, LB/LH/LW, SB/SH/SW) stepping FETCH/LOAD/WRITEBACK over a 3 KiB internal RAM.
// Latency: READ_CYCLE_LATENCY+2 cycles per instruction, 2*READ_CYCLE_LATENCY+3 for loads.
// No backpressure: free-running; RAM powers up zeroed.
module rv32_stage_hart
    import isa_types::*;
#(
    parameter logic [31:0] RESET_VECTOR       = 32'h0,
    parameter logic [31:0] STACK_START        = 32'hC00,
    parameter int unsigned READ_CYCLE_LATENCY = 2
) (
    input  logic   clock,
    input  logic   reset,
    output state_t reg_state
);

    localparam int                CNT_W      = 8;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(READ_CYCLE_LATENCY);

    stage_t            stage;
    stage_t            stage_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              cnt_zero;

    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   xregs [NUM_XREGS];
    logic [ILEN-1:0]   instr_q;
    logic [XLEN-1:0]   load_q;

    logic [ILEN-1:0]   dec_in;
    logic [6:0]        dec_opcode;
    rv_reg_t           dec_rs1;
    rv_reg_t           dec_rs2;
    rv_reg_t           dec_rd;
    logic [2:0]        dec_funct3;
    logic [6:0]        dec_funct7_unused;
    logic [XLEN-1:0]   dec_imm_i;
    logic [XLEN-1:0]   dec_imm_s;

    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   eff_addr_i;
    logic [XLEN-1:0]   eff_addr_s;
    write_width_t      acc_width;
    logic              acc_ok;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;

    logic [XLEN-1:0]   mem_addr;
    logic [3:0]        mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_in_range;
    logic [9:0]        mem_idx;

    logic              rd_we;
    logic [XLEN-1:0]   rd_wdata;

    assign cnt_zero = (wait_cnt == '0);

    // While fetching, decode straight off the RAM so the LOAD/WRITEBACK decision is ready at capture time.
    assign dec_in = (stage == FETCH) ? mem_rdata : instr_q;

    instruction_decoder u_decoder (
        .instr  (dec_in),
        .opcode (dec_opcode),
        .rs1    (dec_rs1),
        .rs2    (dec_rs2),
        .rd     (dec_rd),
        .funct3 (dec_funct3),
        .funct7 (dec_funct7_unused),
        .imm_i  (dec_imm_i),
        .imm_s  (dec_imm_s)
    );

    assign rs1_val    = (dec_rs1 == '0) ? '0 : xregs[dec_rs1];
    assign rs2_val    = (dec_rs2 == '0) ? '0 : xregs[dec_rs2];
    assign eff_addr_i = rs1_val + dec_imm_i;
    assign eff_addr_s = rs1_val + dec_imm_s;
    assign acc_width  = width_of(dec_funct3);
    assign acc_ok     = width_valid(dec_funct3);
    assign ld_byte    = load_q[{eff_addr_i[1:0], 3'b000} +: 8];
    assign ld_half    = eff_addr_i[1] ? load_q[31:16] : load_q[15:0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage    <= FETCH;
            wait_cnt <= CNT_RELOAD;
        end else begin
            stage <= stage_nxt;
            if (stage_nxt != stage && stage_nxt != WRITEBACK) begin
                wait_cnt <= CNT_RELOAD;
            end else if (!cnt_zero) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        stage_nxt = stage;
        unique case (stage)
            FETCH:     if (cnt_zero) stage_nxt = (dec_opcode == OP_LOAD) ? LOAD : WRITEBACK;
            LOAD:      if (cnt_zero) stage_nxt = WRITEBACK;
            WRITEBACK: stage_nxt = FETCH;
            default:   stage_nxt = FETCH;
        endcase
    end

    always_comb begin
        mem_addr  = pc;
        mem_be    = '0;
        mem_wdata = '0;
        rd_we     = 1'b0;
        rd_wdata  = '0;
        unique case (stage)
            FETCH: mem_addr = pc;
            LOAD:  mem_addr = eff_addr_i;
            WRITEBACK: begin
                mem_addr = eff_addr_s;
                if (dec_opcode == OP_IMM && dec_funct3 == F3_ADDI) begin
                    rd_we    = 1'b1;
                    rd_wdata = eff_addr_i;
                end else if (dec_opcode == OP_LOAD && acc_ok) begin
                    rd_we = 1'b1;
                    case (acc_width)
                        WIDTH_BYTE: rd_wdata = {{24{ld_byte[7]}}, ld_byte};
                        WIDTH_HALF: rd_wdata = {{16{ld_half[15]}}, ld_half};
                        default:    rd_wdata = load_q;
                    endcase
                end else if (dec_opcode == OP_STORE && acc_ok) begin
                    case (acc_width)
                        WIDTH_BYTE: begin
                            mem_be    = 4'b0001 << eff_addr_s[1:0];
                            mem_wdata = {4{rs2_val[7:0]}};
                        end
                        WIDTH_HALF: begin
                            mem_be    = eff_addr_s[1] ? 4'b1100 : 4'b0011;
                            mem_wdata = {2{rs2_val[15:0]}};
                        end
                        default: begin
                            mem_be    = 4'b1111;
                            mem_wdata = rs2_val;
                        end
                    endcase
                end
            end
            default: mem_addr = pc;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_VECTOR;
            instr_q <= '0;
            load_q  <= '0;
            for (int i = 0; i < NUM_XREGS; i++) begin
                xregs[i] <= (i == 2) ? STACK_START : '0;
            end
        end else begin
            if (stage == FETCH && cnt_zero) instr_q <= mem_rdata;
            if (stage == LOAD && cnt_zero)  load_q  <= mem_rdata;
            if (stage == WRITEBACK) begin
                pc <= pc + 32'd4;
                if (rd_we && dec_rd != '0) xregs[dec_rd] <= rd_wdata;
            end
        end
    end

    always_comb begin
        reg_state.pc = pc;
        for (int i = 0; i < NUM_XREGS; i++) begin
            reg_state.xregs[i] = (i == 0) ? '0 : xregs[i];
        end
    end

    // Word-organised RAM; sub-word accesses select lanes, so misaligned halves/words land on the aligned word.
    logic [XLEN-1:0] mem [MEM_WORDS] = '{default: '0};

    assign mem_in_range = (mem_addr < 32'(MEM_BYTES));
    assign mem_idx      = mem_addr[11:2];

    always_ff @(posedge clock) begin
        mem_rdata <= mem_in_range ? mem[mem_idx] : '0;
        if (mem_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_rv32_stage_hart.sv
// Directed program for rv32_stage_hart; a monitor checks each retirement against a scoreboard queue.
module tb_rv32_stage_hart;
    import isa_types::*;

    typedef struct {
        logic [31:0] pc;
        int          rd;
        logic [31:0] val;
        int          lat;
    } exp_t;

    logic   clock;
    logic   reset;
    state_t reg_state;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          mon_lat = 0;
    logic [31:0] mon_prev_pc = '0;

    rv32_stage_hart dut (
        .clock     (clock),
        .reset     (reset),
        .reg_state (reg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int pc_after, input int rd, input logic [31:0] val, input int lat);
        exp_t e;
        e.pc  = 32'(pc_after);
        e.rd  = rd;
        e.val = val;
        e.lat = lat;
        sb_q.push_back(e);
    endtask

    task automatic issue(input int addr, input logic [31:0] instr, input int rd,
                         input logic [31:0] val, input int lat);
        dut.mem[addr / 4] = instr;
        push_exp(addr + 4, rd, val, lat);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) @(negedge clock);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    endtask

    // Retirement monitor: pc moves exactly once per instruction, in WRITEBACK.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                mon_lat     = 0;
                mon_prev_pc = reg_state.pc;
            end else begin
                mon_lat++;
                if (reg_state.pc != mon_prev_pc) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_retire_pc", reg_state.pc, mon_prev_pc);
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("pc_after_%0h", e.pc), reg_state.pc, e.pc);
                        check($sformatf("x%0d_at_pc_%0h", e.rd, e.pc), reg_state.xregs[e.rd], e.val);
                        check($sformatf("latency_at_pc_%0h", e.pc), 32'(mon_lat), 32'(e.lat));
                    end
                    mon_prev_pc = reg_state.pc;
                    mon_lat     = 0;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("reset_pc", reg_state.pc, 32'h0);
        check("reset_x0", reg_state.xregs[0], 32'h0);
        check("reset_x1", reg_state.xregs[1], 32'h0);
        check("reset_x2", reg_state.xregs[2], 32'h0000_0C00);
        check("reset_stage", 32'(dut.stage), 32'(FETCH));
        check("reset_wait_cnt", 32'(dut.wait_cnt), 32'd2);

        issue(32'h00, 32'h0050_0093, 1,  32'h0000_0005, 4); // addi x1,x0,5
        issue(32'h04, 32'h0070_0013, 0,  32'h0000_0000, 4); // addi x0,x0,7
        issue(32'h08, 32'hFE11_2E23, 1,  32'h0000_0005, 4); // sw x1,-4(x2)
        issue(32'h0C, 32'hFFC1_2183, 3,  32'h0000_0005, 7); // lw x3,-4(x2)
        issue(32'h10, 32'h0800_0093, 1,  32'h0000_0080, 4); // addi x1,x0,0x80
        issue(32'h14, 32'h0010_0023, 1,  32'h0000_0080, 4); // sb x1,0(x0)
        issue(32'h18, 32'h0000_0203, 4,  32'hFFFF_FF80, 7); // lb x4,0(x0)
        issue(32'h1C, 32'h0000_1283, 5,  32'h0000_0080, 7); // lh x5,0(x0)
        issue(32'h20, 32'hFFF0_0393, 7,  32'hFFFF_FFFF, 4); // addi x7,x0,-1
        issue(32'h24, 32'h0001_2383, 7,  32'h0000_0000, 7); // lw x7,0(x2): beyond RAM
        issue(32'h28, 32'hFFD1_2403, 8,  32'h0000_0005, 7); // lw x8,-3(x2): misaligned
        issue(32'h2C, 32'h0000_4083, 1,  32'h0000_0080, 7); // funct3=100 load: no write
        issue(32'h30, 32'h0010_2093, 1,  32'h0000_0080, 4); // slti: no write
        issue(32'h34, 32'h1234_50B7, 1,  32'h0000_0080, 4); // lui: no-op
        issue(32'h38, 32'hFFF0_8593, 11, 32'h0000_007F, 4); // addi x11,x1,-1
        issue(32'h3C, 32'h0011_2023, 1,  32'h0000_0080, 4); // sw x1,0(x2): ignored
        dut.mem[32'h40 / 4] = 32'hFFC1_2603;                // lw x12,-4(x2): interrupted

        @(negedge clock);
        #1 reset = 1'b1;
        wait_drain(400);

        for (int i = 0; i < 20 && dut.stage != LOAD; i++) @(negedge clock);
        check("reached_load_stage", 32'(dut.stage), 32'(LOAD));
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midload_reset_pc", reg_state.pc, 32'h0);
        check("midload_reset_x12", reg_state.xregs[12], 32'h0);
        check("midload_reset_x2", reg_state.xregs[2], 32'h0000_0C00);
        check("midload_reset_stage", 32'(dut.stage), 32'(FETCH));
        repeat (3) @(negedge clock);
        check("mem_bfc_kept", dut.mem[32'hBFC / 4], 32'h0000_0005);
        check("mem_000_kept", dut.mem[0], 32'h0050_0080);
        check("mem_040_kept", dut.mem[32'h40 / 4], 32'hFFC1_2603);

        // Word 0 now has opcode 0 after the byte store, so it retires as a no-op.
        push_exp(32'h04, 1, 32'h0, 4);
        push_exp(32'h08, 0, 32'h0, 4);
        @(negedge clock);
        #1 reset = 1'b1;
        wait_drain(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32_stage_hart.md
RV32_STAGE_HART -- requirements
Module: rv32_stage_hart

Interface
REQ-001 Parameters SHALL be: RESET_VECTOR, default 0x0, initial pc; STACK_START, default 0xC00, initial sp (x2); READ_CYCLE_LATENCY, default 2, extra wait cycles per memory read.
REQ-002 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Port: clock  input  1  rising-edge system clock.
REQ-004 Port: reset  input  1  asynchronous active-low reset.
REQ-005 Port: reg_state  output  state_t (1056 bits)  architectural state: pc[31:0] and xregs[0:31][31:0].

Function
REQ-006 Stage FSM SHALL have exactly three states: FETCH, LOAD, WRITEBACK.
REQ-007 Wait counter SHALL reload to READ_CYCLE_LATENCY on entry to FETCH or LOAD, and decrement each cycle while nonzero.
REQ-008 FETCH SHALL drive memory address = pc; at counter==0, capture instruction word, go to LOAD if opcode==0000011, else WRITEBACK.
REQ-009 LOAD SHALL drive address = xregs[rs1] + sign-extended I-immediate; at counter==0, capture read data and go to WRITEBACK.
REQ-010 WRITEBACK SHALL last one cycle, commit results, set pc = pc+4 (mod 2^32), and return to FETCH.
REQ-011 Latency at default: non-load instruction 4 cycles; load 7 cycles.
REQ-012 OP_IMM (0010011) funct3 000 (ADDI) SHALL write rs1 + I-imm to rd; other funct3 write nothing.
REQ-013 LOAD funct3 000/001/010 (LB/LH/LW) SHALL write sign-extended byte/halfword/word to rd; other funct3 write nothing.
REQ-014 STORE (0100011) funct3 000/001/010 (SB/SH/SW) SHALL write low 8/16/32 bits of xregs[rs2] at xregs[rs1] + S-imm during WRITEBACK; other funct3 write nothing.
REQ-015 Writes to x0 SHALL be discarded; x0 SHALL always read 0.
REQ-016 All other opcodes SHALL be no-ops that still advance pc by 4.
REQ-017 Internal memory SHALL be 3072 bytes (0x000–0xBFF), little-endian, synchronous write, registered read.
REQ-018 Reads SHALL return bytes addr..addr+3 in bits 7:0 up to 31:24.
REQ-019 Half/word accesses SHALL be naturally aligned; misaligned accesses SHALL use the address with low bits cleared.
REQ-020 Reads at addresses ≥0xC00 SHALL return 0; writes there SHALL be ignored.

Reset
REQ-021 Reset low SHALL immediately (asynchronously) force: stage FETCH, counter READ_CYCLE_LATENCY, pc RESET_VECTOR, x2 STACK_START, all other xregs 0.
REQ-022 Reset mid-instruction SHALL abandon the instruction with no register or memory write.
REQ-023 Memory contents SHALL NOT be affected by reset.

Configuration
REQ-024 With MEM_INIT_EN defined, memory SHALL be initialised at elaboration from hex file "program.hex" (32-bit words from address 0).
REQ-025 Without MEM_INIT_EN, memory SHALL initialise to all zeros (executes as no-ops).

Structure
REQ-026 Package isa_types SHALL hold XLEN=32, ILEN=32, opcode_t, rv_reg_t, write_width_t (byte/halfword/word), state_t, and funct3 constants.
REQ-027 Sub-module instruction_decoder SHALL be purely combinational, mapping instruction bits to opcode, rs1, rs2, rd, funct3, funct7, I-imm, S-imm.
REQ-028 During FETCH, decoder input SHALL be the live memory read data; otherwise it SHALL be the captured instruction.

Verification
REQ-029 Reset release -> pc=0, x0=0, x2=0xC00, stage FETCH.
REQ-030 0x00500093 (addi x1,x0,5) at 0 -> x1=5, pc=4 after 4 cycles.
REQ-031 0x00700013 (addi x0,x0,7) -> x0 stays 0, pc+4.
REQ-032 x1=5; sw x1,-4(x2); lw x3,-4(x2) -> mem[0xBFC]=5, x3=5; load takes 7 cycles.
REQ-033 x1=0x80; sb x1,0(x0); lb x4,0(x0); lh x5,0(x0) -> x4=0xFFFFFF80, x5=0x00000080.
REQ-034 Assert reset during LOAD wait -> pc=0 immediately, rd unchanged, no memory write.
